// File: rtl/mips_pkg.sv
// mips_pkg: types shared by the MIPS pipeline stages.
//   load_mode_e : memory access width / extension encoding used by the MEM stage
//   mem_state_e : MEM-stage access FSM states
package mips_pkg;

  typedef enum logic [1:0] {
    LM_WORD   = 2'b00,
    LM_HALF_S = 2'b01,
    LM_BYTE_S = 2'b10,
    LM_BYTE_U = 2'b11
  } load_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_load_extract.sv
// mem_load_extract: picks the addressed byte/halfword lane from a read word
// and sign- or zero-extends it according to the load mode.
//   rdata_i [31:0] : raw word returned by data memory
//   addr_i  [1:0]  : byte offset within the word (little-endian)
//   mode_i  [1:0]  : load_mode_e encoding
//   data_o  [31:0] : extended load result
module mem_load_extract
  import mips_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  mode_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
  // addr_i[0] is not used for halfwords: an odd halfword address reads the
  // halfword that contains it.
  assign half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (load_mode_e'(mode_i))
      LM_WORD:   data_o = rdata_i;
      LM_HALF_S: data_o = {{16{half_lane[15]}}, half_lane};
      LM_BYTE_S: data_o = {{24{byte_lane[7]}}, byte_lane};
      LM_BYTE_U: data_o = {24'd0, byte_lane};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage MIPS pipeline.
// Takes the EX/MEM register outputs, runs a req/ack data-memory access
// (stalling the front of the pipe while it is outstanding), steers store
// lanes, extracts/extends load data and registers the MEM/WB pipeline register.
//   clk, rst_n                  : clock, async active-low reset
//   in_*                        : EX/MEM control, ALU result, store data, branch target
//   mem_req/we/addr/wdata/be    : data memory request port
//   mem_ack, mem_rdata          : data memory completion / read data
//   stall_out                   : freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//   pc_src_out, branch_target_out : combinational branch resolution
//   RegWrite_out .. writebackDestination_out : MEM/WB register
// Optional feature, macro MEM_STAGE_ALIGN_CHECK_EN: misaligned word/half
// accesses are dropped and flagged on addr_err_out.
module mem_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_RegWrite,
  input  logic        in_MemWrite,
  input  logic        in_MemRead,
  input  logic        in_MemToReg,
  input  logic        in_Branch,
  input  logic        in_zero,
  input  logic [1:0]  in_load_mode,
  input  logic [4:0]  in_writebackDestination,
  input  logic [31:0] in_aluResult,
  input  logic [31:0] in_rt,
  input  logic [31:0] in_pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_out,
  output logic        pc_src_out,
  output logic [31:0] branch_target_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] read_data_out,
  output logic [31:0] aluResult_out,
  output logic [4:0]  writebackDestination_out
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  ,
  output logic        addr_err_out
`endif
);

  mem_state_e  state_q, state_d;
  logic        acc, misalign;
  logic [1:0]  a;
  logic [31:0] load_data;

  logic        RegWrite_q, MemToReg_q;
  logic [31:0] read_data_q, aluResult_q;
  logic [4:0]  dest_q;

  assign acc = in_MemRead | in_MemWrite;
  assign a   = in_aluResult[1:0];

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic addr_err_q;
  assign misalign = acc &
                    (((load_mode_e'(in_load_mode) == LM_WORD)   && (a != 2'b00)) ||
                     ((load_mode_e'(in_load_mode) == LM_HALF_S) && a[0]));
  assign addr_err_out = addr_err_q;
`else
  assign misalign = 1'b0;
`endif

  // Request/stall/strobe are gated by rst_n so they drop the instant reset
  // asserts, not at the next edge.
  assign mem_req   = rst_n & ((state_q == ST_BUSY) | (acc & ~misalign));
  assign stall_out = mem_req & ~mem_ack;
  assign mem_we    = mem_req & in_MemWrite;
  assign mem_addr  = {in_aluResult[31:2], 2'b00};

  assign pc_src_out        = in_Branch & in_zero;
  assign branch_target_out = in_pc;

  // Store lane steering; reads always fetch the full word.
  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = in_rt;
    if (in_MemWrite) begin
      case (load_mode_e'(in_load_mode))
        LM_WORD: begin
          mem_be    = 4'b1111;
          mem_wdata = in_rt;
        end
        LM_HALF_S: begin
          mem_be    = a[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{in_rt[15:0]}};
        end
        default: begin
          mem_be    = 4'b0001 << a;
          mem_wdata = {4{in_rt[7:0]}};
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acc && !misalign && !mem_ack) state_d = ST_BUSY;
      ST_BUSY: if (mem_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  mem_load_extract u_extract (
    .rdata_i (mem_rdata),
    .addr_i  (a),
    .mode_i  (in_load_mode),
    .data_o  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // MEM/WB register. Not stalled means either no access, a dropped
  // misaligned access, or the access completes (ack) this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_q  <= 1'b0;
      MemToReg_q  <= 1'b0;
      read_data_q <= '0;
      aluResult_q <= '0;
      dest_q      <= '0;
    end else if (stall_out) begin
      // bubble: kill write-back, hold data fields
      RegWrite_q <= 1'b0;
      MemToReg_q <= 1'b0;
    end else begin
      RegWrite_q  <= in_RegWrite & ~misalign;
      MemToReg_q  <= in_MemToReg;
      read_data_q <= (in_MemRead & ~misalign) ? load_data : 32'd0;
      aluResult_q <= in_aluResult;
      dest_q      <= in_writebackDestination;
    end
  end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_err_q <= 1'b0;
    else        addr_err_q <= misalign;
  end
`endif

  assign RegWrite_out             = RegWrite_q;
  assign MemToReg_out             = MemToReg_q;
  assign read_data_out            = read_data_q;
  assign aluResult_out            = aluResult_q;
  assign writebackDestination_out = dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table-driven bench for mem_stage, plus hand-written
// sequences for the multi-cycle stall, reset-in-BUSY and (when
// MEM_STAGE_ALIGN_CHECK_EN is defined) misaligned-access cases.
module tb_mem_stage;

  logic        clk, rst_n;
  logic        in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg, in_Branch, in_zero;
  logic [1:0]  in_load_mode;
  logic [4:0]  in_writebackDestination;
  logic [31:0] in_aluResult, in_rt, in_pc;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_out, pc_src_out;
  logic [31:0] branch_target_out;
  logic        RegWrite_out, MemToReg_out;
  logic [31:0] read_data_out, aluResult_out;
  logic [4:0]  writebackDestination_out;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic        addr_err_out;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_RegWrite(in_RegWrite), .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead),
    .in_MemToReg(in_MemToReg), .in_Branch(in_Branch), .in_zero(in_zero),
    .in_load_mode(in_load_mode), .in_writebackDestination(in_writebackDestination),
    .in_aluResult(in_aluResult), .in_rt(in_rt), .in_pc(in_pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_out(stall_out), .pc_src_out(pc_src_out), .branch_target_out(branch_target_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .read_data_out(read_data_out), .aluResult_out(aluResult_out),
    .writebackDestination_out(writebackDestination_out)
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    , .addr_err_out(addr_err_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rw, mw, mr, m2r, br, zero;
    logic [1:0]  mode;
    logic [4:0]  dest;
    logic [31:0] alu, rt, pc, rdata;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_addr, e_rd;
  } vec_t;

  vec_t vec[10];

  function automatic vec_t mk(string name, logic rw, logic mw, logic mr, logic m2r,
                              logic br, logic zero, logic [1:0] mode, logic [4:0] dest,
                              logic [31:0] alu, logic [31:0] rt, logic [31:0] pc,
                              logic [31:0] rdata, logic [3:0] e_be, logic [31:0] e_wdata,
                              logic [31:0] e_addr, logic [31:0] e_rd);
    vec_t v;
    v.name = name; v.rw = rw; v.mw = mw; v.mr = mr; v.m2r = m2r; v.br = br; v.zero = zero;
    v.mode = mode; v.dest = dest; v.alu = alu; v.rt = rt; v.pc = pc; v.rdata = rdata;
    v.e_be = e_be; v.e_wdata = e_wdata; v.e_addr = e_addr; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(vec_t v, logic ack);
    in_RegWrite = v.rw; in_MemWrite = v.mw; in_MemRead = v.mr; in_MemToReg = v.m2r;
    in_Branch = v.br; in_zero = v.zero; in_load_mode = v.mode;
    in_writebackDestination = v.dest; in_aluResult = v.alu; in_rt = v.rt; in_pc = v.pc;
    mem_rdata = v.rdata; mem_ack = ack;
  endtask

  task automatic idle_inputs();
    drive(mk("nop", 0,0,0,0,0,0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0,
             4'hF, 32'h0, 32'h0, 32'h0), 1'b0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] prev_alu;
    //            name    rw mw mr m2r br z  mode  dest   alu           rt            pc            rdata         be    wdata         addr          rd
    vec[0] = mk("lw",     1, 0, 1, 1,  0, 0, 2'b00, 5'd8, 32'h0000_0100, 32'h0,        32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0,        32'h0000_0100, 32'hDEAD_BEEF);
    vec[1] = mk("lbu",    1, 0, 1, 1,  0, 0, 2'b11, 5'd9, 32'h0000_0101, 32'h0,        32'h0000_1004, 32'h0000_F500, 4'hF, 32'h0,        32'h0000_0100, 32'h0000_00F5);
    vec[2] = mk("sh",     0, 1, 0, 0,  0, 0, 2'b01, 5'd0, 32'h0000_0202, 32'h0000_ABCD, 32'h0000_1008, 32'h0,       4'hC, 32'hABCD_ABCD, 32'h0000_0200, 32'h0);
    vec[3] = mk("sh_lo",  0, 1, 0, 0,  0, 0, 2'b01, 5'd0, 32'h0000_0200, 32'h1234_5678, 32'h0000_100C, 32'h0,       4'h3, 32'h5678_5678, 32'h0000_0200, 32'h0);
    vec[4] = mk("sb",     0, 1, 0, 0,  0, 0, 2'b10, 5'd0, 32'h0000_0203, 32'h1234_5678, 32'h0000_1010, 32'h0,       4'h8, 32'h7878_7878, 32'h0000_0200, 32'h0);
    vec[5] = mk("lh_hi",  1, 0, 1, 1,  0, 0, 2'b01, 5'd10, 32'h0000_0102, 32'h0,       32'h0000_1014, 32'h8001_1234, 4'hF, 32'h0,        32'h0000_0100, 32'hFFFF_8001);
    vec[6] = mk("lh_lo",  1, 0, 1, 1,  0, 0, 2'b01, 5'd11, 32'h0000_0100, 32'h0,       32'h0000_1018, 32'h0001_7FFF, 4'hF, 32'h0,        32'h0000_0100, 32'h0000_7FFF);
    vec[7] = mk("alu_br", 1, 0, 0, 0,  1, 1, 2'b00, 5'd12, 32'h0000_0055, 32'h1111_2222, 32'h0000_0400, 32'h0,    4'hF, 32'h1111_2222, 32'h0000_0054, 32'h0);
    vec[8] = mk("sw",     0, 1, 0, 0,  1, 0, 2'b00, 5'd0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0000_0800, 32'h0,       4'hF, 32'hCAFE_F00D, 32'h0000_0300, 32'h0);
    vec[9] = mk("lb_pos", 1, 0, 1, 1,  0, 0, 2'b10, 5'd13, 32'h0000_0101, 32'h0,       32'h0000_1020, 32'h0000_7F00, 4'hF, 32'h0,        32'h0000_0100, 32'h0000_007F);

    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk("rst_RegWrite", {31'd0, RegWrite_out}, 32'd0);
    chk("rst_read_data", read_data_out, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table: every access acked in its request cycle (zero-wait memory)
    for (int i = 0; i < 10; i++) begin
      v = vec[i];
      @(negedge clk);
      drive(v, 1'b1);
      #1;
      chk({v.name, "_req"},    {31'd0, mem_req},    {31'd0, v.mr | v.mw});
      chk({v.name, "_we"},     {31'd0, mem_we},     {31'd0, v.mw});
      chk({v.name, "_addr"},   mem_addr,  v.e_addr);
      chk({v.name, "_be"},     {28'd0, mem_be},     {28'd0, v.e_be});
      chk({v.name, "_wdata"},  mem_wdata, v.e_wdata);
      chk({v.name, "_stall"},  {31'd0, stall_out},  32'd0);
      chk({v.name, "_pcsrc"},  {31'd0, pc_src_out}, {31'd0, v.br & v.zero});
      chk({v.name, "_target"}, branch_target_out, v.pc);
      @(posedge clk);
      #1;
      chk({v.name, "_rd"},   read_data_out, v.e_rd);
      chk({v.name, "_rw"},   {31'd0, RegWrite_out}, {31'd0, v.rw});
      chk({v.name, "_m2r"},  {31'd0, MemToReg_out}, {31'd0, v.m2r});
      chk({v.name, "_alu"},  aluResult_out, v.alu);
      chk({v.name, "_dest"}, {27'd0, writebackDestination_out}, {27'd0, v.dest});
    end
    prev_alu = vec[9].alu;

    // lb at 0x103, ack arrives on the 4th cycle -> 3 stall cycles
    v = mk("lb_slow", 1, 0, 1, 1, 0, 0, 2'b10, 5'd14, 32'h0000_0103, 32'h0, 32'h0,
           32'h8011_2233, 4'hF, 32'h0, 32'h0000_0100, 32'hFFFF_FF80);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(v, 1'b0);
      #1;
      chk($sformatf("slow_stall%0d", c), {31'd0, stall_out}, 32'd1);
      chk($sformatf("slow_req%0d", c),   {31'd0, mem_req},   32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("slow_bubble_rw%0d", c), {31'd0, RegWrite_out}, 32'd0);
      chk($sformatf("slow_hold_alu%0d", c),  aluResult_out, prev_alu);
    end
    @(negedge clk);
    drive(v, 1'b1);
    #1;
    chk("slow_ack_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk);
    #1;
    chk("slow_rd", read_data_out, 32'hFFFF_FF80);
    chk("slow_rw", {31'd0, RegWrite_out}, 32'd1);
    chk("slow_dest", {27'd0, writebackDestination_out}, 32'd14);

    // after the ack the FSM is back in IDLE: no request with no access
    @(negedge clk);
    idle_inputs();
    mem_ack = 1'b1;  // ack must be ignored while no request is out
    #1;
    chk("post_idle_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_idle_rd", read_data_out, 32'd0);

    // reset while BUSY
    @(negedge clk);
    drive(vec[0], 1'b0);
    @(posedge clk);  // now BUSY
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstb_req",   {31'd0, mem_req},   32'd0);
    chk("rstb_stall", {31'd0, stall_out}, 32'd0);
    chk("rstb_we",    {31'd0, mem_we},    32'd0);
    chk("rstb_alu",   aluResult_out, 32'd0);
    chk("rstb_dest",  {27'd0, writebackDestination_out}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    chk("rstb_idle_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("rstb_no_wb", {31'd0, RegWrite_out}, 32'd0);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    @(negedge clk);
    drive(mk("lw_mis", 1, 0, 1, 1, 0, 0, 2'b00, 5'd15, 32'h0000_0102, 32'h0, 32'h0,
             32'h1234_5678, 4'hF, 32'h0, 32'h0000_0100, 32'h0), 1'b0);
    #1;
    chk("mis_req",   {31'd0, mem_req},   32'd0);
    chk("mis_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk);
    #1;
    chk("mis_err", {31'd0, addr_err_out}, 32'd1);
    chk("mis_rw",  {31'd0, RegWrite_out}, 32'd0);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("mis_err_pulse", {31'd0, addr_err_out}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
